// File: rtl/cim_pkg.sv
// Shared CIM tile types: 6x6 signed 12-bit tiles packed into one 512-bit SRAM word.
package cim_pkg;
  localparam int TILE_DIM  = 6;
  localparam int PIX_W     = 12;
  localparam int WORD_W    = 512;
  localparam int OD_W      = 8;
  localparam int ADDR_W    = 8;
  localparam int TILE_BITS = TILE_DIM * TILE_DIM * PIX_W;

  typedef logic signed [PIX_W-1:0] pix_t;
  typedef pix_t [0:TILE_DIM-1][0:TILE_DIM-1] tile_t;

  typedef struct packed {
    tile_t             tile;
    logic [OD_W-1:0]   od;
    logic [ADDR_W-1:0] addr;
  } tile_entry_t;

  typedef struct packed {
    logic              port;
    logic [OD_W-1:0]   od;
    logic [ADDR_W-1:0] addr;
  } rd_tag_t;

  // Pixel (i,j) sits at bit offset (i*6+j)*12; the top 80 bits of the word carry nothing.
  function automatic tile_t unpack_tile(input logic [WORD_W-1:0] word);
    tile_t t;
    logic  unused_hi;
    unused_hi = ^word[WORD_W-1:TILE_BITS];
    for (int i = 0; i < TILE_DIM; i++) begin
      for (int j = 0; j < TILE_DIM; j++) begin
        t[i][j] = word[(i*TILE_DIM+j)*PIX_W +: PIX_W];
      end
    end
    return t;
  endfunction
endpackage

// File: rtl/cim_tile_fifo.sv
// Small synchronous FIFO of tagged tiles; the head is presented combinationally and reads 0 when empty.
module cim_tile_fifo
  import cim_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  tile_entry_t      wr_data,
  input  logic             pop,
  output tile_entry_t      rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  tile_entry_t      mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so push+pop on a full FIFO is accepted.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];
  assign count   = count_reg;
endmodule

// File: rtl/cim_tile_reader.sv
// Two-port tile reader: round-robin arbitration onto one SRAM read port, tag pipe, per-port output FIFOs.
module cim_tile_reader
  import cim_pkg::*;
#(
  parameter int READ_LAT   = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              req_valid_i_1,
  output logic              req_ready_o_1,
  input  logic [OD_W-1:0]   req_od_i_1,
  input  logic [ADDR_W-1:0] req_addr_i_1,
  input  logic              req_valid_i_2,
  output logic              req_ready_o_2,
  input  logic [OD_W-1:0]   req_od_i_2,
  input  logic [ADDR_W-1:0] req_addr_i_2,
  output logic              mem_rd_en_o,
  output logic [OD_W-1:0]   mem_rd_od_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [WORD_W-1:0] mem_rd_data_i,
  output tile_t             tile_o_1,
  output logic [OD_W-1:0]   tile_od_o_1,
  output logic [ADDR_W-1:0] tile_addr_o_1,
  output logic              tile_valid_o_1,
  input  logic              tile_ready_i_1,
  output tile_t             tile_o_2,
  output logic [OD_W-1:0]   tile_od_o_2,
  output logic [ADDR_W-1:0] tile_addr_o_2,
  output logic              tile_valid_o_2,
  input  logic              tile_ready_i_2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        req_valid;
  logic [1:0]        tile_ready;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic [1:0]        push;
  logic [1:0]        fifo_empty;
  logic [1:0]        unused_full;
  tile_entry_t       fifo_head [2];
  tile_entry_t       land_entry;
  logic              rr_reg;
  logic              mem_rd_en_reg;
  logic [OD_W-1:0]   mem_rd_od_reg;
  logic [ADDR_W-1:0] mem_rd_addr_reg;
  logic              issue_port_reg;
  logic              tag_valid_reg [READ_LAT];
  rd_tag_t           tag_reg [READ_LAT];

  assign req_valid  = {req_valid_i_2, req_valid_i_1};
  assign tile_ready = {tile_ready_i_2, tile_ready_i_1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [CNT_W-1:0] inflight_reg;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit;

    // Reserving a slot for every read in flight means a landing tile always finds room.
    assign credit       = {1'b0, fifo_count} + {1'b0, inflight_reg};
    assign eligible[gi] = en_i && req_valid[gi] && (credit < (CNT_W+1)'(FIFO_DEPTH));
    assign push[gi]     = tag_valid_reg[READ_LAT-1] && (tag_reg[READ_LAT-1].port == 1'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        inflight_reg <= '0;
      end else begin
        case ({grant[gi], push[gi]})
          2'b10:   inflight_reg <= inflight_reg + 1'b1;
          2'b01:   inflight_reg <= inflight_reg - 1'b1;
          default: ;
        endcase
      end
    end

    cim_tile_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push[gi]),
      .wr_data (land_entry),
      .pop     (!fifo_empty[gi] && tile_ready[gi]),
      .rd_data (fifo_head[gi]),
      .count   (fifo_count),
      .full    (unused_full[gi]),
      .empty   (fifo_empty[gi])
    );
  end

  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) grant = rr_reg ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg          <= 1'b0;
      mem_rd_en_reg   <= 1'b0;
      mem_rd_od_reg   <= '0;
      mem_rd_addr_reg <= '0;
      issue_port_reg  <= 1'b0;
    end else begin
      mem_rd_en_reg <= |grant;
      if (|grant) begin
        rr_reg          <= grant[0];
        issue_port_reg  <= grant[1];
        mem_rd_od_reg   <= grant[1] ? req_od_i_2 : req_od_i_1;
        mem_rd_addr_reg <= grant[1] ? req_addr_i_2 : req_addr_i_1;
      end
    end
  end

  // Tags follow the issued strobe so the last stage lines up with returning read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LAT; k++) tag_valid_reg[k] <= 1'b0;
    end else begin
      tag_valid_reg[0] <= mem_rd_en_reg;
      for (int k = 1; k < READ_LAT; k++) tag_valid_reg[k] <= tag_valid_reg[k-1];
    end
    tag_reg[0] <= '{port: issue_port_reg, od: mem_rd_od_reg, addr: mem_rd_addr_reg};
    for (int k = 1; k < READ_LAT; k++) tag_reg[k] <= tag_reg[k-1];
  end

  assign land_entry = '{tile: unpack_tile(mem_rd_data_i),
                        od:   tag_reg[READ_LAT-1].od,
                        addr: tag_reg[READ_LAT-1].addr};

  assign req_ready_o_1  = grant[0];
  assign req_ready_o_2  = grant[1];
  assign mem_rd_en_o    = mem_rd_en_reg;
  assign mem_rd_od_o    = mem_rd_od_reg;
  assign mem_rd_addr_o  = mem_rd_addr_reg;
  assign tile_o_1       = fifo_head[0].tile;
  assign tile_od_o_1    = fifo_head[0].od;
  assign tile_addr_o_1  = fifo_head[0].addr;
  assign tile_valid_o_1 = !fifo_empty[0];
  assign tile_o_2       = fifo_head[1].tile;
  assign tile_od_o_2    = fifo_head[1].od;
  assign tile_addr_o_2  = fifo_head[1].addr;
  assign tile_valid_o_2 = !fifo_empty[1];
endmodule

// File: tb/tb_cim_tile_reader.sv
// Bench for cim_tile_reader: directed steps plus random traffic against a queue-based reference model.
module tb_cim_tile_reader;
  import cim_pkg::*;

  localparam int READ_LAT   = 1;
  localparam int FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rst, en_i;
  logic req_valid_i_1, req_ready_o_1, req_valid_i_2, req_ready_o_2;
  logic [7:0] req_od_i_1, req_addr_i_1, req_od_i_2, req_addr_i_2;
  logic mem_rd_en_o;
  logic [7:0] mem_rd_od_o, mem_rd_addr_o;
  logic [511:0] mem_rd_data_i;
  tile_t tile_o_1, tile_o_2;
  logic [7:0] tile_od_o_1, tile_addr_o_1, tile_od_o_2, tile_addr_o_2;
  logic tile_valid_o_1, tile_ready_i_1, tile_valid_o_2, tile_ready_i_2;

  int checks = 0;
  int errors = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  int grant_log[$];
  logic [511:0] special [int];
  logic [511:0] dpipe [READ_LAT];

  always #5 clk = ~clk;

  cim_tile_reader #(.READ_LAT(READ_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .en_i(en_i),
    .req_valid_i_1(req_valid_i_1), .req_ready_o_1(req_ready_o_1),
    .req_od_i_1(req_od_i_1), .req_addr_i_1(req_addr_i_1),
    .req_valid_i_2(req_valid_i_2), .req_ready_o_2(req_ready_o_2),
    .req_od_i_2(req_od_i_2), .req_addr_i_2(req_addr_i_2),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_od_o(mem_rd_od_o), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_rd_data_i(mem_rd_data_i),
    .tile_o_1(tile_o_1), .tile_od_o_1(tile_od_o_1), .tile_addr_o_1(tile_addr_o_1),
    .tile_valid_o_1(tile_valid_o_1), .tile_ready_i_1(tile_ready_i_1),
    .tile_o_2(tile_o_2), .tile_od_o_2(tile_od_o_2), .tile_addr_o_2(tile_addr_o_2),
    .tile_valid_o_2(tile_valid_o_2), .tile_ready_i_2(tile_ready_i_2)
  );

  function automatic logic [511:0] sram_word(input logic [7:0] od, input logic [7:0] addr);
    logic [511:0] w;
    int key;
    key = int'({od, addr});
    if (special.exists(key)) return special[key];
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = {od, addr, 8'(k), od ^ addr ^ 8'(k*37)};
    return w;
  endfunction

  // SRAM model: garbage on idle cycles so any stale capture shows up.
  always @(posedge clk) begin
    dpipe[0] <= mem_rd_en_o ? sram_word(mem_rd_od_o, mem_rd_addr_o) : {16{32'hDEADBEEF}};
    for (int k = 1; k < READ_LAT; k++) dpipe[k] <= dpipe[k-1];
  end
  assign mem_rd_data_i = dpipe[READ_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_tile(input int p, input tile_t t, input logic [7:0] od, input logic [7:0] addr);
    logic [15:0] e;
    logic [511:0] w;
    int bad;
    if ((p == 1 && q1.size() == 0) || (p == 2 && q2.size() == 0)) begin
      chk($sformatf("p%0d_unexpected_tile", p), 1, 0);
      return;
    end
    e = (p == 1) ? q1.pop_front() : q2.pop_front();
    $display("tile p%0d od=%0d addr=%0d", p, od, addr);
    chk($sformatf("p%0d_od", p), od, e[15:8]);
    chk($sformatf("p%0d_addr", p), addr, e[7:0]);
    w = sram_word(e[15:8], e[7:0]);
    bad = 0;
    for (int k = 0; k < 36; k++) if (t[k/6][k%6] !== w[k*12 +: 12]) bad++;
    chk($sformatf("p%0d_pixels_bad", p), bad, 0);
  endtask

  // Reference model: every accepted request must come back once, in order, on its own port.
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      if (req_ready_o_1 && req_ready_o_2) chk("dual_grant", 1, 0);
      if (req_valid_i_1 && req_ready_o_1) q1.push_back({req_od_i_1, req_addr_i_1});
      if (req_valid_i_2 && req_ready_o_2) q2.push_back({req_od_i_2, req_addr_i_2});
      if (tile_valid_o_1 && tile_ready_i_1) check_tile(1, tile_o_1, tile_od_o_1, tile_addr_o_1);
      if (tile_valid_o_2 && tile_ready_i_2) check_tile(2, tile_o_2, tile_od_o_2, tile_addr_o_2);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n1, input int n2, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] od1, input logic [7:0] od2, input int budget,
                        output int g1, output int g2);
    g1 = 0;
    g2 = 0;
    for (int c = 0; c < budget && (g1 < n1 || g2 < n2); c++) begin
      next();
      req_valid_i_1 = (g1 < n1); req_addr_i_1 = b1 + 8'(g1); req_od_i_1 = od1;
      req_valid_i_2 = (g2 < n2); req_addr_i_2 = b2 + 8'(g2); req_od_i_2 = od2;
      @(negedge clk);
      if (req_valid_i_1 && req_ready_o_1) begin g1++; grant_log.push_back(1); end
      if (req_valid_i_2 && req_ready_o_2) begin g2++; grant_log.push_back(2); end
    end
    next();
    req_valid_i_1 = 1'b0;
    req_valid_i_2 = 1'b0;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((q1.size() != 0 || q2.size() != 0 || tile_valid_o_1 || tile_valid_o_2) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(tag, c < 200, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int g1, g2, rem, alt_bad, rd_cnt, rdy_cnt, stale, c;
    logic [511:0] w;
    logic signed [11:0] px;

    rst = 1'b1; en_i = 1'b0;
    req_valid_i_1 = 1'b0; req_od_i_1 = '0; req_addr_i_1 = '0;
    req_valid_i_2 = 1'b0; req_od_i_2 = '0; req_addr_i_2 = '0;
    tile_ready_i_1 = 1'b1; tile_ready_i_2 = 1'b1;
    repeat (3) next();
    @(negedge clk);
    chk("rst_valid1", tile_valid_o_1, 0);
    chk("rst_valid2", tile_valid_o_2, 0);
    chk("rst_rd_en", mem_rd_en_o, 0);
    chk("rst_rd_od", mem_rd_od_o, 0);
    chk("rst_rd_addr", mem_rd_addr_o, 0);
    next(); rst = 1'b0;
    @(negedge clk);
    chk("rst_tile1_zero", (tile_o_1 == '0), 1);
    chk("rst_ready1", req_ready_o_1, 0);

    // Single request, latency and content.
    for (int k = 0; k < 42; k++) w[k*12 +: 12] = 12'hCC;
    w[511:504] = 8'hCC;
    special[3] = w;
    next(); en_i = 1'b1; req_valid_i_1 = 1'b1; req_od_i_1 = 8'd0; req_addr_i_1 = 8'd3;
    @(negedge clk); chk("t1_ready", req_ready_o_1, 1);
    next(); req_valid_i_1 = 1'b0;
    @(negedge clk);
    chk("t1_rd_en", mem_rd_en_o, 1);
    chk("t1_rd_addr", mem_rd_addr_o, 3);
    chk("t1_rd_od", mem_rd_od_o, 0);
    for (int k = 2; k <= READ_LAT + 1; k++) begin
      next(); @(negedge clk); chk("t1_early_valid", tile_valid_o_1, 0);
    end
    next(); @(negedge clk);
    chk("t1_valid", tile_valid_o_1, 1);
    chk("t1_pix00", tile_o_1[0][0], 12'h0CC);
    chk("t1_pix55", tile_o_1[5][5], 12'h0CC);
    chk("t1_addr", tile_addr_o_1, 3);
    drain("t1_drain");

    // Both ports streaming: grants must alternate.
    grant_log.delete();
    stream(8, 8, 8'd0, 8'd8, 8'($urandom), 8'($urandom), 200, g1, g2);
    chk("t2_g1", g1, 8);
    chk("t2_g2", g2, 8);
    alt_bad = 0;
    for (int i = 1; i < grant_log.size(); i++) if (grant_log[i] == grant_log[i-1]) alt_bad++;
    chk("t2_alternation", alt_bad, 0);
    drain("t2_drain");

    // Port 1 stalled: credits cap its grants, port 2 keeps going.
    tile_ready_i_1 = 1'b0;
    stream(6, 6, 8'h20, 8'h40, 8'd7, 8'd9, 20, g1, g2);
    chk("t3_p1_grants", g1, FIFO_DEPTH);
    chk("t3_p2_grants", g2, 6);
    rem = 6 - g1;
    @(negedge clk);
    chk("t3_head_valid", tile_valid_o_1, 1);
    chk("t3_head_addr", tile_addr_o_1, 8'h20);
    repeat (3) next();
    @(negedge clk);
    chk("t3_head_hold", tile_addr_o_1, 8'h20);
    next(); tile_ready_i_1 = 1'b1;
    stream(rem, 0, 8'h20 + 8'(6 - rem), 8'h00, 8'd7, 8'd0, 100, g1, g2);
    chk("t3_rest", g1, rem);
    drain("t3_drain");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      next();
      en_i = ($urandom_range(0, 7) != 0);
      req_valid_i_1 = 1'($urandom); req_od_i_1 = 8'($urandom); req_addr_i_1 = 8'($urandom);
      req_valid_i_2 = 1'($urandom); req_od_i_2 = 8'($urandom); req_addr_i_2 = 8'($urandom);
      tile_ready_i_1 = 1'($urandom); tile_ready_i_2 = 1'($urandom);
    end
    next();
    req_valid_i_1 = 1'b0; req_valid_i_2 = 1'b0; en_i = 1'b1;
    tile_ready_i_1 = 1'b1; tile_ready_i_2 = 1'b1;
    drain("rand_drain");

    // Sign extension and ignored upper bits.
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
    w[11:0] = 12'h800;
    w[35*12 +: 12] = 12'h7FF;
    w[511:432] = '1;
    special[5*256 + 9] = w;
    next(); req_valid_i_2 = 1'b1; req_od_i_2 = 8'd5; req_addr_i_2 = 8'd9;
    @(negedge clk); chk("sgn_ready", req_ready_o_2, 1);
    next(); req_valid_i_2 = 1'b0;
    c = 0;
    @(negedge clk);
    while (!tile_valid_o_2 && c < 20) begin @(negedge clk); c++; end
    chk("sgn_arrived", tile_valid_o_2, 1);
    px = tile_o_2[0][0];
    chk("sgn_pix00", longint'(px), 64'(-2048));
    px = tile_o_2[5][5];
    chk("sgn_pix55", longint'(px), 64'(2047));
    drain("sgn_drain");

    // en_i falls right after a grant.
    next(); en_i = 1'b1; req_valid_i_1 = 1'b1; req_od_i_1 = 8'd1; req_addr_i_1 = 8'd42;
    @(negedge clk); chk("en_ready", req_ready_o_1, 1);
    next(); en_i = 1'b0;
    rd_cnt = 0; rdy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rd_cnt += int'(mem_rd_en_o);
      rdy_cnt += int'(req_ready_o_1);
      next();
    end
    chk("en_rd_pulses", rd_cnt, 1);
    chk("en_no_grant", rdy_cnt, 0);
    req_valid_i_1 = 1'b0; en_i = 1'b1;
    drain("en_drain");

    // Reset with two reads in flight.
    next(); req_valid_i_1 = 1'b1; req_od_i_1 = 8'd2; req_addr_i_1 = 8'd50;
    @(negedge clk); chk("rf_ready1", req_ready_o_1, 1);
    next(); req_valid_i_1 = 1'b0; req_valid_i_2 = 1'b1; req_od_i_2 = 8'd3; req_addr_i_2 = 8'd60;
    @(negedge clk); chk("rf_ready2", req_ready_o_2, 1);
    next(); req_valid_i_2 = 1'b0; rst = 1'b1;
    @(negedge clk);
    next(); rst = 1'b0;
    @(negedge clk);
    chk("rf_valid1", tile_valid_o_1, 0);
    chk("rf_valid2", tile_valid_o_2, 0);
    chk("rf_rd_en", mem_rd_en_o, 0);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      next(); @(negedge clk);
      stale += int'(tile_valid_o_1) + int'(tile_valid_o_2);
    end
    chk("rf_stale", stale, 0);
    next();
    req_valid_i_1 = 1'b1; req_od_i_1 = 8'd4; req_addr_i_1 = 8'd70;
    req_valid_i_2 = 1'b1; req_od_i_2 = 8'd4; req_addr_i_2 = 8'd80;
    @(negedge clk);
    chk("rf_prio1", req_ready_o_1, 1);
    chk("rf_prio2", req_ready_o_2, 0);
    next(); req_valid_i_1 = 1'b0;
    @(negedge clk); chk("rf_then2", req_ready_o_2, 1);
    next(); req_valid_i_2 = 1'b0;
    drain("rf_drain");

    chk("end_q1_empty", q1.size(), 0);
    chk("end_q2_empty", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
